// File: rtl/qpsk_symbol_serializer.sv
// qpsk_symbol_serializer
// Accepts bytes over a valid/ready handshake into a one-byte holding register
// and emits them as four 2-bit QPSK symbols, one every SYM_DIV clocks. Each
// symbol is marked by a one-cycle wren strobe. A byte waiting in the holding
// register is reloaded at the end of the current byte, so the symbol stream
// has no gap between back-to-back bytes.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | shift register empty; waits for the holding register to fill
// SHIFT | emitting the four symbols of the byte in the shift register
module qpsk_symbol_serializer #(
  parameter int unsigned SYM_DIV   = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [1:0] dout,
  output logic       wren,
  output logic       busy
);

  localparam logic [0:0]  ST_IDLE  = 1'b0;
  localparam logic [0:0]  ST_SHIFT = 1'b1;
  localparam logic [15:0] DIV_LAST = 16'(SYM_DIV - 1);

  logic [0:0]  state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [7:0]  sh_q, sh_d;
  logic [1:0]  sym_idx_q, sym_idx_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic        wren_q, wren_d;
  logic [1:0]  dout_q, dout_d;

  logic        take;
  logic        load;

  // Next-state logic: handshake, FSM, symbol divider and shift register.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sh_d        = sh_q;
    sym_idx_d   = sym_idx_q;
    div_cnt_d   = div_cnt_q;
    wren_d      = 1'b0;
    dout_d      = dout_q;
    load        = 1'b0;

    // s_ready is only ever high while hold is empty, so a transfer and a
    // reload can never coincide.
    take = s_valid && !hold_full_q;

    case (state_q)
      ST_IDLE: begin
        div_cnt_d = 16'd0;
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (div_cnt_q == 16'd0) begin
          wren_d = 1'b1;
          if (MSB_FIRST) begin
            dout_d = sh_q[7:6];
            sh_d   = {sh_q[5:0], 2'b00};
          end else begin
            dout_d = sh_q[1:0];
            sh_d   = {2'b00, sh_q[7:2]};
          end
        end

        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = 16'd0;
          sym_idx_d = sym_idx_q + 2'd1;
          if (sym_idx_q == 2'd3) begin
            // End of byte: continue seamlessly if another byte is waiting.
            if (hold_full_q) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A reload takes priority over the shift of the final symbol.
    if (load) begin
      sh_d        = hold_q;
      hold_full_d = 1'b0;
      sym_idx_d   = 2'd0;
      div_cnt_d   = 16'd0;
    end

    if (take) begin
      hold_d      = s_data;
      hold_full_d = 1'b1;
    end
  end

  // State registers with synchronous reset; reset also drops any transfer
  // presented on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      sh_q        <= 8'd0;
      sym_idx_q   <= 2'd0;
      div_cnt_q   <= 16'd0;
      wren_q      <= 1'b0;
      dout_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sh_q        <= sh_d;
      sym_idx_q   <= sym_idx_d;
      div_cnt_q   <= div_cnt_d;
      wren_q      <= wren_d;
      dout_q      <= dout_d;
    end
  end

  assign s_ready = !hold_full_q;
  assign dout    = dout_q;
  assign wren    = wren_q;
  assign busy    = (state_q == ST_SHIFT) || hold_full_q;

endmodule

// File: tb/tb_qpsk_symbol_serializer.sv
// Testbench for qpsk_symbol_serializer: three instances cover SYM_DIV=4 MSB
// first, SYM_DIV=4 LSB first and SYM_DIV=1. Stimulus pushes hand-computed
// symbols and emission cycles into per-instance queues; a forked monitor pops
// and compares them whenever an instance raises wren.
module tb_qpsk_symbol_serializer;

  typedef struct {
    logic [1:0] d;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst     [3];
  logic [7:0] s_data  [3];
  logic       s_valid [3];
  logic       s_ready [3];
  logic [1:0] dout    [3];
  logic       wren    [3];
  logic       busy    [3];

  exp_t exp_q [3][$];
  int   last_x [3];
  int   seen   [3];
  int   cyc;
  int   checks;
  int   errors;

  qpsk_symbol_serializer #(.SYM_DIV(4), .MSB_FIRST(1'b1)) u_dut0 (
    .clk(clk), .rst(rst[0]), .s_data(s_data[0]), .s_valid(s_valid[0]),
    .s_ready(s_ready[0]), .dout(dout[0]), .wren(wren[0]), .busy(busy[0])
  );

  qpsk_symbol_serializer #(.SYM_DIV(4), .MSB_FIRST(1'b0)) u_dut1 (
    .clk(clk), .rst(rst[1]), .s_data(s_data[1]), .s_valid(s_valid[1]),
    .s_ready(s_ready[1]), .dout(dout[1]), .wren(wren[1]), .busy(busy[1])
  );

  qpsk_symbol_serializer #(.SYM_DIV(1), .MSB_FIRST(1'b1)) u_dut2 (
    .clk(clk), .rst(rst[2]), .s_data(s_data[2]), .s_valid(s_valid[2]),
    .s_ready(s_ready[2]), .dout(dout[2]), .wren(wren[2]), .busy(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: at the falling edge after rising edge N it reads N.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something blocks outside the bounded loops.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic int div_of(input int id);
    return (id == 2) ? 1 : 4;
  endfunction

  task automatic chk(input string name, input int id, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h, expected %0h (cycle %0d)", name, id, act, req, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (wren[i] === 1'b1) begin
          seen[i]++;
          checks++;
          if (exp_q[i].size() == 0) begin
            errors++;
            $display("FAIL unexpected_wren dut%0d: dout=%0d at cycle %0d, no symbol pending", i, dout[i], cyc);
          end else begin
            e = exp_q[i].pop_front();
            if (dout[i] !== e.d || cyc != e.cyc) begin
              errors++;
              $display("FAIL symbol dut%0d: got dout=%0d at cycle %0d, expected dout=%0d at cycle %0d",
                       i, dout[i], cyc, e.d, e.cyc);
            end
          end
        end
      end
    end
  endtask

  // Offer one byte; exp_d holds the four expected dibits, first emitted in [7:6].
  // Called at a falling edge, returns at the falling edge after the transfer.
  task automatic send(input int id, input logic [7:0] b, input logic [7:0] exp_d);
    int   e0;
    int   first;
    int   budget;
    int   dv;
    exp_t e;
    dv = div_of(id);
    s_data[id]  = b;
    s_valid[id] = 1'b1;
    budget = 0;
    while (s_ready[id] !== 1'b1 && budget < 200) begin
      @(posedge clk);
      @(negedge clk);
      budget++;
    end
    if (s_ready[id] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d: s_ready stayed %b for byte %0h", id, s_ready[id], b);
      s_valid[id] = 1'b0;
      return;
    end
    e0    = cyc + 1;
    first = (e0 + 2 > last_x[id] + 1) ? e0 + 2 : last_x[id] + 1;
    for (int k = 0; k < 4; k++) begin
      e.d   = exp_d[7-2*k -: 2];
      e.cyc = first + k * dv;
      exp_q[id].push_back(e);
    end
    last_x[id] = first + 4 * dv - 1;
    @(posedge clk);
    @(negedge clk);
    s_valid[id] = 1'b0;
    chk("s_ready_after_accept", id, {7'd0, s_ready[id]}, 8'd0);
    chk("busy_after_accept", id, {7'd0, busy[id]}, 8'd1);
  endtask

  // Wait for all pending symbols, then confirm the block has gone idle.
  task automatic drain(input int id);
    int b;
    b = 0;
    while (exp_q[id].size() != 0 && b < 300) begin
      @(negedge clk);
      b++;
    end
    if (exp_q[id].size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout dut%0d: %0d symbols never emitted", id, exp_q[id].size());
      exp_q[id].delete();
    end
    repeat (div_of(id) + 3) @(negedge clk);
    chk("busy_idle", id, {7'd0, busy[id]}, 8'd0);
    chk("s_ready_idle", id, {7'd0, s_ready[id]}, 8'd1);
  endtask

  initial begin
    int base;
    int b;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 3; i++) begin
      rst[i]     = 1'b1;
      s_valid[i] = 1'b0;
      s_data[i]  = 8'h00;
      last_x[i]  = 0;
      seen[i]    = 0;
    end
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_wren", i, {7'd0, wren[i]}, 8'd0);
      chk("reset_dout", i, {6'd0, dout[i]}, 8'd0);
      chk("reset_s_ready", i, {7'd0, s_ready[i]}, 8'd1);
      chk("reset_busy", i, {7'd0, busy[i]}, 8'd0);
      rst[i] = 1'b0;
    end
    repeat (2) @(negedge clk);

    // 0xB4, MSB first, SYM_DIV=4: 2,3,1,0
    send(0, 8'hB4, {2'd2, 2'd3, 2'd1, 2'd0});
    @(negedge clk);
    chk("s_ready_after_load", 0, {7'd0, s_ready[0]}, 8'd1);
    chk("busy_while_shifting", 0, {7'd0, busy[0]}, 8'd1);
    drain(0);

    // 0xB4, LSB first: 0,1,3,2
    send(1, 8'hB4, {2'd0, 2'd1, 2'd3, 2'd2});
    drain(1);

    // SYM_DIV=1, valid held across 0x1B then 0xE4: eight gapless symbols
    send(2, 8'h1B, {2'd0, 2'd1, 2'd2, 2'd3});
    send(2, 8'hE4, {2'd3, 2'd2, 2'd1, 2'd0});
    drain(2);

    // Three back-to-back bytes at SYM_DIV=4: twelve evenly spaced symbols
    send(0, 8'h1B, {2'd0, 2'd1, 2'd2, 2'd3});
    send(0, 8'hE4, {2'd3, 2'd2, 2'd1, 2'd0});
    send(0, 8'hB4, {2'd2, 2'd3, 2'd1, 2'd0});
    drain(0);

    // Reset after the second symbol of 0xFF, with a byte offered on the reset edge
    base = seen[0];
    send(0, 8'hFF, {2'd3, 2'd3, 2'd3, 2'd3});
    b = 0;
    while (seen[0] < base + 2 && b < 100) begin
      @(negedge clk);
      b++;
    end
    chk("symbols_before_reset", 0, 8'(seen[0] - base), 8'd2);
    rst[0]     = 1'b1;
    s_valid[0] = 1'b1;
    s_data[0]  = 8'h55;
    exp_q[0].delete();
    last_x[0] = 0;
    @(posedge clk);
    @(negedge clk);
    rst[0]     = 1'b0;
    s_valid[0] = 1'b0;
    chk("midreset_wren", 0, {7'd0, wren[0]}, 8'd0);
    chk("midreset_dout", 0, {6'd0, dout[0]}, 8'd0);
    chk("midreset_s_ready", 0, {7'd0, s_ready[0]}, 8'd1);
    chk("midreset_busy", 0, {7'd0, busy[0]}, 8'd0);
    repeat (20) @(negedge clk);
    chk("no_wren_after_reset", 0, 8'(seen[0] - base), 8'd2);

    send(0, 8'h00, {2'd0, 2'd0, 2'd0, 2'd0});
    drain(0);

    for (int i = 0; i < 3; i++) begin
      chk("queue_empty_at_end", i, 8'(exp_q[i].size()), 8'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qpsk_symbol_serializer.md
QPSK_SYMBOL_SERIALIZER -- requirements
Module: qpsk_symbol_serializer

Interface
REQ-001 Parameter SYM_DIV, default 4: clock cycles per QPSK symbol; legal range 1..65535.
REQ-002 Parameter MSB_FIRST, default 1: 1 emits bits [7:6] first; 0 emits bits [1:0] first.
REQ-003 Port clk  input  1: single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst  input  1: synchronous, active-high reset.
REQ-005 Port s_data  input  8: byte to be transmitted.
REQ-006 Port s_valid  input  1: s_data valid.
REQ-007 Port s_ready  output  1: block can accept a byte; a transfer occurs on an edge where s_valid and s_ready are both high.
REQ-008 Port dout  output  2: dibit symbol feeding the QPSK mapper din.
REQ-009 Port wren  output  1: one-cycle strobe marking a new dout, feeding the mapper wren.
REQ-010 Port busy  output  1: high while any accepted bit has not yet been emitted.

Function
REQ-011 Storage SHALL be a one-byte holding register (hold, hold_full) plus an 8-bit shift register, a 2-bit symbol index (sym_idx) and a 16-bit divider (div_cnt).
REQ-012 s_ready SHALL equal !hold_full, taken directly from a register with no combinational path from s_valid.
REQ-013 On transfer, hold SHALL capture s_data and hold_full SHALL set on that edge.
REQ-014 A byte offered while hold_full is 1 SHALL NOT be accepted; the source SHALL keep s_valid and s_data stable until accepted.
REQ-015 FSM states: IDLE and SHIFT.
REQ-016 IDLE with hold_full=1: on the next edge, load the shift register from hold, clear hold_full, set sym_idx=0 and div_cnt=0, and go to SHIFT.
REQ-017 IDLE with hold_full=0: remain in IDLE with div_cnt held at 0.
REQ-018 SHIFT, div_cnt==0: on that edge, register wren=1 and dout=current symbol (MSB_FIRST=1: sh[7:6], then shift left by 2; MSB_FIRST=0: sh[1:0], then shift right by 2).
REQ-019 In all other cycles wren SHALL be registered 0, and dout SHALL hold its last value.
REQ-020 SHIFT: div_cnt SHALL increment each cycle and wrap from SYM_DIV-1 to 0; sym_idx SHALL increment at each wrap.
REQ-021 The end-of-byte point is the edge where div_cnt==SYM_DIV-1 and sym_idx==3.
REQ-022 At end-of-byte with hold_full=1: reload the shift register from hold, clear hold_full, wrap div_cnt to 0, stay in SHIFT (gapless symbol stream).
REQ-023 At end-of-byte with hold_full=0: go to IDLE.
REQ-024 SYM_DIV=1: div_cnt is constantly 0, wren is high every cycle in SHIFT, and the end-of-byte edge coincides with the 4th symbol's emit edge.
REQ-025 Latency: for a transfer on edge E0 into an idle block, the first wren SHALL be visible after edge E0+2; symbol k SHALL be visible after edge E0+2+k*SYM_DIV.
REQ-026 Exactly 4 wren pulses SHALL be produced per accepted byte, in bit order, with no loss or duplication.
REQ-027 Transfer and reload on the same edge is impossible (s_ready=0 when reload occurs); a new byte SHALL be accepted on the edge after hold_full clears.
REQ-028 busy SHALL equal (state==SHIFT) || hold_full.

Reset
REQ-029 rst=1 at an edge SHALL set state=IDLE, hold_full=0, div_cnt=0, sym_idx=0, shift register=0, wren=0, dout=2'b00, s_ready=1, busy=0.
REQ-030 Reset mid-byte SHALL discard all unsent symbols, and no wren SHALL follow the reset edge until a new byte is accepted.
REQ-031 A transfer presented on the reset edge SHALL be ignored.

Verification
REQ-032 SYM_DIV=4, MSB_FIRST=1, send 0xB4 -> wren pulses 4 cycles apart, first 2 cycles after transfer; dout=2,3,1,0; busy then falls.
REQ-033 MSB_FIRST=0, send 0xB4 -> dout=0,1,3,2.
REQ-034 SYM_DIV=1, s_valid held with 0x1B then 0xE4 -> 8 consecutive wren cycles with no gap; dout=0,1,2,3,3,2,1,0.
REQ-035 SYM_DIV=4, three bytes presented back-to-back -> s_ready low while hold is full; all 12 symbols emitted in order, evenly 4 cycles apart.
REQ-036 Reset after the 2nd symbol of 0xFF -> wren=0 and dout=0 from the reset edge; s_ready=1; no further wren pulses; the next byte 0x00 yields dout=0,0,0,0 with normal latency.
